serial_add: RTL
===============

SERIAL_ADD -- requirements
Module: serial_add

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 4, bits processed per clock; SHALL divide WIDTH exactly, and 1 <= DIGIT <= WIDTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  operands present on a, b, ci, sub.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 ci  input  1  carry-in for add; borrow-in for subtract.
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 out_valid  output  1  sum, cout and ovf are valid.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.

Function
REQ-016 FSM states SHALL be IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1; on in_valid=1, capture a, b, ci and sub and go to RUN; otherwise stay in IDLE.
REQ-018 Capture: b_eff = sub ? ~b : b and c0 = sub ? ~ci : ci, so add gives a+b+ci and subtract gives a-b-ci.
REQ-019 RUN: each cycle adds DIGIT bits of a and b_eff, least significant group first, plus the held carry; it writes DIGIT sum bits and updates the carry register.
REQ-020 Step count N = WIDTH/DIGIT; RUN lasts exactly N cycles, tracked by a counter of ceil(log2(N+1)) bits; after the last step go to DONE.
REQ-021 DONE: out_valid=1, in_ready=0; on out_ready=1 go to IDLE; otherwise hold sum, cout and ovf stable.
REQ-022 Latency: with out_ready held at 1, acceptance at edge k gives out_valid high during cycle k+N, and in_ready returns high at cycle k+N+1.
REQ-023 in_ready SHALL be 0 in RUN and DONE; in_valid and operand changes there SHALL be ignored.
REQ-024 cout = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-025 When DIGIT=WIDTH, N=1; one RUN cycle, then DONE.
REQ-026 sum, cout and ovf SHALL change only during RUN and on reset; they keep their last value in IDLE.
REQ-027 out_valid and in_ready SHALL be driven from registered state only, with no combinational path from in_valid or out_ready.

Reset
REQ-028 rst_n=0 SHALL, asynchronously and from any state: force IDLE, clear the step counter, carry, sum, cout and ovf to 0, set out_valid=0, and set in_ready=1 from the first cycle after deassertion.
REQ-029 Reset during RUN or DONE SHALL discard the operation in progress; no out_valid pulse follows.
REQ-030 Deassertion of rst_n is synchronous to clk; the first accept is possible on the first rising edge after deassertion.

Verification
REQ-031 WIDTH=16, DIGIT=4, add: a=0x1234, b=0x0FCD, ci=1 -> after 4 RUN cycles sum=0x2202, cout=0, ovf=0.
REQ-032 Add with wrap: a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, cout=1, ovf=0; and a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
REQ-033 Subtract: a=0x0005, b=0x0007, ci=0, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0; and a=0x8000, b=0x0001 -> sum=0x7FFF, ovf=1.
REQ-034 Backpressure: hold out_ready=0 for 10 cycles in DONE while toggling in_valid and operands -> outputs stable, in_ready=0; out_ready=1 -> IDLE on the next cycle.
REQ-035 Reset mid-RUN: assert rst_n=0 after 2 RUN cycles -> immediately out_valid=0 and sum=0; after release in_ready=1, and no spurious out_valid.
REQ-036 Parameter sweep: DIGIT in {1, 2, 4, 16} with 1000 random operations each -> every result matches the reference model; each op takes WIDTH/DIGIT RUN cycles.

Source files
------------

// File: rtl/serial_add.sv
// Digit-serial adder/subtractor: captures operands, adds DIGIT bits per clock
// LSB group first, then holds the result with valid/ready handshaking.
module serial_add #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // state | meaning
    // IDLE  | waiting for an operation, in_ready high
    // RUN   | one DIGIT-wide slice added per clock, N clocks total
    // DONE  | result presented with out_valid, held until out_ready

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   dfull;
    logic [DIGIT-1:0] dsum;
    logic             msb_cin;

    assign dfull = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry};
    assign dsum  = dfull[DIGIT-1:0];
    // carry into the top bit of the current slice, recovered from its sum bit
    assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ dsum[DIGIT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= sub ? ~b : b;
                        carry    <= sub ? ~ci : ci;
                        cnt      <= CW'(N);
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> DIGIT;
                    b_q   <= b_q >> DIGIT;
                    carry <= dfull[DIGIT];
                    // new slice enters at the top; after N shifts it lands in place
                    sum   <= WIDTH'({dsum, sum} >> DIGIT);
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        cout      <= dfull[DIGIT];
                        ovf       <= msb_cin ^ dfull[DIGIT];
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
